gin_bus_buffered: RTL and testbench

Buffered, partial-delivery successor to the GIN row bus: accepts tagged values from the GIN source, queues them in a FIFO of parametrised depth, and multicasts each value to every PE master whose scan-chain-loaded ID matches the tag. Delivery is tracked per master, so ready masters take the value immediately and busy masters receive it later. The entry is retired only when all targeted masters have accepted it. The block sits between the GIN top-level router and one PE row. It adds a broadcast tag and an unmatched-tag indication.

---
 rtl/gin_bus_buffered.sv | 163 ++++++++++++++++
 tb/tb_gin_bus_buffered.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gin_bus_buffered.sv
// Buffered GIN row bus: queues tagged values and multicasts each head entry to every
// master whose scan-loaded ID matches, retiring it once all targets have handshaken.
module gin_bus_buffered #(
    parameter int unsigned MASTER_NUMS = 14,
    parameter int unsigned ID_LEN      = 5,
    parameter int unsigned VALUE_LEN   = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter bit          BCAST_EN    = 1'b1,
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VALUE_LEN+ID_LEN:0]     enable_tag_value,
    output logic                          ready,
    input  logic [MASTER_NUMS-1:0]        master_ready,
    output logic [MASTER_NUMS-1:0]        master_valid,
    output logic [VALUE_LEN-1:0]          master_value,
    input  logic                          set_id,
    input  logic [ID_LEN-1:0]             id_scan_in,
    output logic [ID_LEN-1:0]             id_scan_out,
    output logic [CW-1:0]                 fifo_count,
    output logic                          unmatched,
    output logic                          busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [ID_LEN-1:0]    id_q      [MASTER_NUMS];
    logic [ID_LEN-1:0]    tag_mem_q [FIFO_DEPTH];
    logic [VALUE_LEN-1:0] val_mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [0:0]           state_q, state_d;
    logic [MASTER_NUMS-1:0] pending_q, pending_d;
    logic                 unmatched_q, unmatched_d;

    logic                 in_en;
    logic [ID_LEN-1:0]    in_tag;
    logic [VALUE_LEN-1:0] in_value;
    logic [ID_LEN-1:0]    head_tag;
    logic                 head_bcast;
    logic [MASTER_NUMS-1:0] mask;
    logic [MASTER_NUMS-1:0] remaining;
    logic                 fifo_empty;
    logic                 push, pop;

    assign in_en    = enable_tag_value[VALUE_LEN+ID_LEN];
    assign in_tag   = enable_tag_value[VALUE_LEN+ID_LEN-1:VALUE_LEN];
    assign in_value = enable_tag_value[VALUE_LEN-1:0];

    assign fifo_empty = (count_q == '0);
    assign ready      = (count_q < DepthC) && !set_id;
    assign push       = in_en && ready;

    assign head_tag   = tag_mem_q[rptr_q];
    assign head_bcast = BCAST_EN && (head_tag == {ID_LEN{1'b1}});

    always_comb begin
        mask = '0;
        for (int i = 0; i < MASTER_NUMS; i++) begin
            mask[i] = (id_q[i] == head_tag) | head_bcast;
        end
    end

    assign remaining = pending_q & ~master_ready;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        unmatched_d = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !set_id) begin
                    if (mask != '0) begin
                        pending_d = mask;
                        state_d   = SEND;
                    end else begin
                        pop         = 1'b1;
                        unmatched_d = 1'b1;
                    end
                end
            end
            SEND: begin
                pending_d = remaining;
                if (remaining == '0) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MASTER_NUMS; i++) begin
                id_q[i] <= '0;
            end
        end else if (set_id) begin
            id_q[0] <= id_scan_in;
            for (int i = 1; i < MASTER_NUMS; i++) begin
                id_q[i] <= id_q[i-1];
            end
        end
    end

    // Storage is reset so master_value never shows X before the first entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
                val_mem_q[i] <= '0;
            end
        end else if (push) begin
            tag_mem_q[wptr_q] <= in_tag;
            val_mem_q[wptr_q] <= in_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            pending_q   <= '0;
            unmatched_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q     <= count_d;
            state_q     <= state_d;
            pending_q   <= pending_d;
            unmatched_q <= unmatched_d;
        end
    end

    assign master_valid = (state_q == SEND) ? pending_q : '0;
    assign master_value = val_mem_q[rptr_q];
    assign id_scan_out  = id_q[MASTER_NUMS-1];
    assign fifo_count   = count_q;
    assign unmatched    = unmatched_q;
    assign busy         = !fifo_empty || (state_q == SEND);

endmodule

// File: tb/tb_gin_bus_buffered.sv
// Directed bench for gin_bus_buffered: scan chain, unicast, staggered multicast,
// broadcast, backpressure, unmatched drop and asynchronous reset mid-delivery.
module tb_gin_bus_buffered;

    logic        clk;
    logic        rst;
    logic [37:0] enable_tag_value;
    logic        ready;
    logic [13:0] master_ready;
    logic [13:0] master_valid;
    logic [31:0] master_value;
    logic        set_id;
    logic [4:0]  id_scan_in;
    logic [4:0]  id_scan_out;
    logic [2:0]  fifo_count;
    logic        unmatched;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [4:0] ids_tb [14];

    gin_bus_buffered dut (
        .clk              (clk),
        .rst              (rst),
        .enable_tag_value (enable_tag_value),
        .ready            (ready),
        .master_ready     (master_ready),
        .master_valid     (master_valid),
        .master_value     (master_value),
        .set_id           (set_id),
        .id_scan_in       (id_scan_in),
        .id_scan_out      (id_scan_out),
        .fifo_count       (fifo_count),
        .unmatched        (unmatched),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] tag, input logic [31:0] val);
        enable_tag_value = {1'b1, tag, val};
        step();
        enable_tag_value = '0;
    endtask

    // First value shifted lands in the last master, so shift ids_tb[13] first.
    task automatic scan_ids(input bit chk);
        set_id = 1'b1;
        for (int k = 0; k < 14; k++) begin
            id_scan_in = ids_tb[13-k];
            #1;
            if (chk) begin
                total_cnt++;
                if (ready !== 1'b0) $display("FAIL scan_ready k=%0d got %b want 0", k, ready);
                else pass_cnt++;
            end
            step();
        end
        set_id = 1'b0;
        id_scan_in = '0;
    endtask

    task automatic ids_identity();
        for (int i = 0; i < 14; i++) ids_tb[i] = 5'(i);
        scan_ids(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_id = 1'b0;
        id_scan_in = '0;
        enable_tag_value = '0;
        master_ready = '0;
        #3;
        total_cnt++;
        if ({ready, fifo_count, busy, unmatched} !== {1'b1, 3'd0, 1'b0, 1'b0})
            $display("FAIL reset_ctrl got r=%b c=%0d b=%b u=%b want r=1 c=0 b=0 u=0",
                     ready, fifo_count, busy, unmatched);
        else pass_cnt++;
        total_cnt++;
        if ({master_valid, master_value, id_scan_out} !== {14'h0, 32'h0, 5'h0})
            $display("FAIL reset_out got v=%h val=%h so=%h want 0", master_valid,
                     master_value, id_scan_out);
        else pass_cnt++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_scan();
        for (int i = 0; i < 14; i++) ids_tb[i] = 5'(13 - i);
        scan_ids(1'b1);
        total_cnt++;
        if (id_scan_out !== 5'd0) $display("FAIL scan_out14 got %0d want 0", id_scan_out);
        else pass_cnt++;
        // One more shift: id[i] becomes 14-i, so the scan output shows 1.
        set_id = 1'b1;
        id_scan_in = 5'd14;
        step();
        set_id = 1'b0;
        total_cnt++;
        if (id_scan_out !== 5'd1) $display("FAIL scan_out15 got %0d want 1", id_scan_out);
        else pass_cnt++;
        master_ready = '1;
        push(5'd9, 32'h0000_0099);
        step();
        total_cnt++;
        if (master_valid !== 14'h0020) $display("FAIL scan_map got %h want 0020", master_valid);
        else pass_cnt++;
        step();
    endtask

    task automatic test_unicast();
        ids_identity();
        master_ready = '1;
        push(5'd5, 32'hDEAD_BEEF);
        total_cnt++;
        if ({fifo_count, master_valid} !== {3'd1, 14'h0})
            $display("FAIL uni_n1 got c=%0d v=%h want c=1 v=0", fifo_count, master_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({master_valid, master_value} !== {14'h0020, 32'hDEAD_BEEF})
            $display("FAIL uni_n2 got v=%h val=%h want v=0020 val=deadbeef",
                     master_valid, master_value);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({master_valid, fifo_count, busy} !== {14'h0, 3'd0, 1'b0})
            $display("FAIL uni_done got v=%h c=%0d b=%b want 0", master_valid, fifo_count, busy);
        else pass_cnt++;
    endtask

    task automatic test_staggered();
        for (int i = 0; i < 14; i++) ids_tb[i] = 5'(i);
        ids_tb[2] = 5'd7;
        ids_tb[6] = 5'd7;
        ids_tb[9] = 5'd7;
        ids_tb[7] = 5'd15;
        scan_ids(1'b0);
        master_ready = '0;
        push(5'd7, 32'h0000_1234);
        push(5'd0, 32'h0000_0055);
        master_ready[2] = 1'b1;
        #1;
        total_cnt++;
        if ({master_valid, master_value} !== {14'h0244, 32'h1234})
            $display("FAIL stag_p0 got v=%h val=%h want v=0244 val=1234", master_valid,
                     master_value);
        else pass_cnt++;
        step();
        total_cnt++;
        if (master_valid !== 14'h0240) $display("FAIL stag_p1 got %h want 0240", master_valid);
        else pass_cnt++;
        step();
        step();
        master_ready[6] = 1'b1;
        #1;
        total_cnt++;
        if (master_valid !== 14'h0240) $display("FAIL stag_p3 got %h want 0240", master_valid);
        else pass_cnt++;
        step();
        master_ready[9] = 1'b1;
        #1;
        total_cnt++;
        if ({master_valid, fifo_count} !== {14'h0200, 3'd2})
            $display("FAIL stag_p5 got v=%h c=%0d want v=0200 c=2", master_valid, fifo_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({master_valid, fifo_count} !== {14'h0, 3'd1})
            $display("FAIL stag_pop got v=%h c=%0d want v=0 c=1", master_valid, fifo_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({master_valid, master_value} !== {14'h0001, 32'h55})
            $display("FAIL stag_next got v=%h val=%h want v=0001 val=55", master_valid,
                     master_value);
        else pass_cnt++;
        master_ready = '1;
        step();
        total_cnt++;
        if ({master_valid, fifo_count} !== {14'h0, 3'd0})
            $display("FAIL stag_done got v=%h c=%0d want 0", master_valid, fifo_count);
        else pass_cnt++;
    endtask

    task automatic test_broadcast();
        ids_identity();
        master_ready = 14'h007F;
        push(5'd31, 32'h0000_0B0B);
        step();
        total_cnt++;
        if ({master_valid, master_value} !== {14'h3FFF, 32'h0B0B})
            $display("FAIL bc_all got v=%h val=%h want v=3fff val=0b0b", master_valid,
                     master_value);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({master_valid, fifo_count} !== {14'h3F80, 3'd1})
            $display("FAIL bc_half got v=%h c=%0d want v=3f80 c=1", master_valid, fifo_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if (master_valid !== 14'h3F80) $display("FAIL bc_hold got %h want 3f80", master_valid);
        else pass_cnt++;
        master_ready = '1;
        step();
        total_cnt++;
        if ({master_valid, fifo_count, busy} !== {14'h0, 3'd0, 1'b0})
            $display("FAIL bc_done got v=%h c=%0d b=%b want 0", master_valid, fifo_count, busy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_v [3];
        exp_v[0] = 32'd102;
        exp_v[1] = 32'd103;
        exp_v[2] = 32'd200;
        ids_identity();
        master_ready = '0;
        for (int k = 0; k < 6; k++) begin
            enable_tag_value = {1'b1, 5'd3, 32'(100 + k)};
            #1;
            total_cnt++;
            if (ready !== (k < 4)) $display("FAIL bp_ready k=%0d got %b want %b", k, ready, k < 4);
            else pass_cnt++;
            step();
        end
        enable_tag_value = '0;
        total_cnt++;
        if ({fifo_count, ready, master_valid, master_value} !== {3'd4, 1'b0, 14'h0008, 32'd100})
            $display("FAIL bp_full got c=%0d r=%b v=%h val=%0d want c=4 r=0 v=0008 val=100",
                     fifo_count, ready, master_valid, master_value);
        else pass_cnt++;
        master_ready[3] = 1'b1;
        step();
        total_cnt++;
        if ({fifo_count, master_valid} !== {3'd3, 14'h0})
            $display("FAIL bp_pop1 got c=%0d v=%h want c=3 v=0", fifo_count, master_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({master_valid, master_value} !== {14'h0008, 32'd101})
            $display("FAIL bp_v101 got v=%h val=%0d want v=0008 val=101", master_valid,
                     master_value);
        else pass_cnt++;
        enable_tag_value = {1'b1, 5'd3, 32'd200};
        step();
        enable_tag_value = '0;
        total_cnt++;
        if (fifo_count !== 3'd3) $display("FAIL bp_pushpop got c=%0d want 3", fifo_count);
        else pass_cnt++;
        for (int j = 0; j < 3; j++) begin
            step();
            total_cnt++;
            if ({master_valid, master_value} !== {14'h0008, exp_v[j]})
                $display("FAIL bp_order j=%0d got v=%h val=%0d want v=0008 val=%0d", j,
                         master_valid, master_value, exp_v[j]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({fifo_count, busy} !== {3'd0, 1'b0})
            $display("FAIL bp_empty got c=%0d b=%b want c=0 b=0", fifo_count, busy);
        else pass_cnt++;
    endtask

    task automatic test_unmatched_reset();
        ids_identity();
        master_ready = '1;
        push(5'd20, 32'h0000_00AA);
        total_cnt++;
        if ({unmatched, fifo_count} !== {1'b0, 3'd1})
            $display("FAIL um_n1 got u=%b c=%0d want u=0 c=1", unmatched, fifo_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({unmatched, master_valid, fifo_count} !== {1'b1, 14'h0, 3'd0})
            $display("FAIL um_pulse got u=%b v=%h c=%0d want u=1 v=0 c=0", unmatched,
                     master_valid, fifo_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({unmatched, busy} !== {1'b0, 1'b0})
            $display("FAIL um_end got u=%b b=%b want 0", unmatched, busy);
        else pass_cnt++;
        master_ready = '0;
        push(5'd4, 32'h0000_0077);
        push(5'd4, 32'h0000_0088);
        total_cnt++;
        if ({master_valid, master_value, fifo_count} !== {14'h0010, 32'h77, 3'd2})
            $display("FAIL rs_send got v=%h val=%h c=%0d want v=0010 val=77 c=2",
                     master_valid, master_value, fifo_count);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({master_valid, fifo_count, busy, unmatched, ready} !== {14'h0, 3'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL rs_async got v=%h c=%0d b=%b u=%b r=%b want v=0 c=0 b=0 u=0 r=1",
                     master_valid, fifo_count, busy, unmatched, ready);
        else pass_cnt++;
        total_cnt++;
        if ({master_value, id_scan_out} !== {32'h0, 5'h0})
            $display("FAIL rs_data got val=%h so=%h want 0", master_value, id_scan_out);
        else pass_cnt++;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_unicast();
        test_staggered();
        test_broadcast();
        test_backpressure();
        test_unmatched_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
